// File: rtl/moore_detector_arbiter_if.sv
// rtl/moore_detector_arbiter_if.sv - requester/arbiter bundle for the shared pulse-count detector
//
// Purpose: groups the requester-facing signals of moore_detector_arbiter.
// Signals:
//   req       NREQ  per-requester request level (requester -> arbiter)
//   din       NREQ  per-requester data bit (requester -> arbiter)
//   grant     NREQ  one-hot grant (arbiter -> requester)
//   busy      1     arbiter not idle
//   det_state 2     shared detector state S0..S3
//   done      1     one-cycle completion pulse
//   done_id   IDW   owner index of the last completion
//   timeout   1     one-cycle abort pulse
// Modports: master = requester side, slave = arbiter side.
interface moore_detector_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] din;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic [1:0]      det_state;
  logic            done;
  logic [IDW-1:0]  done_id;
  logic            timeout;

  modport master (
    output req, din,
    input  grant, busy, det_state, done, done_id, timeout
  );

  modport slave (
    input  req, din,
    output grant, busy, det_state, done, done_id, timeout
  );
endinterface

// File: rtl/moore_detector_arbiter.sv
// rtl/moore_detector_arbiter.sv - round-robin owner of a shared Moore pulse-count detector
//
// Purpose: grants one of NREQ requesters at a time, feeds the owner's din bit
// into a 4-state Moore counter (S0..S3) and pulses done with the owner id on
// the third '1'. Optional RUN watchdog enabled by macro ARB_TIMEOUT_EN.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-low reset
//   io_arb  slave modport of moore_detector_arbiter_if
//           (req, din in; grant, busy, det_state, done, done_id, timeout out)
module moore_detector_arbiter #(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  moore_detector_arbiter_if.slave  io_arb
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_ptr, w_ptr_nxt;
  logic [IDW-1:0]  r_owner, w_owner_nxt;
  logic [IDW-1:0]  r_done_id, w_done_id_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [1:0]      r_det, w_det_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [IDW-1:0]  w_ptr_inc;
  logic            w_found;
  logic [IDW-1:0]  w_winner;
  logic [IDW-1:0]  w_sel;
  int              w_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;
`endif

  // Pointer advances past the owner after every completion or abort.
  assign w_ptr_inc = (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + IDW'(1);

  // First requester at or after r_ptr, wrapping at NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    w_sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_sel = IDW'(w_idx);
      if (!w_found && io_arb.req[w_sel]) begin
        w_found  = 1'b1;
        w_winner = w_sel;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_grant_nxt   = r_grant;
    w_det_nxt     = r_det;
    w_done_nxt    = 1'b0;
    w_done_id_nxt = r_done_id;
`ifdef ARB_TIMEOUT_EN
    w_to_cnt_nxt  = r_to_cnt;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        w_det_nxt   = 2'd0;
        if (w_found) begin
          w_state_nxt = S_RUN;
          w_owner_nxt = w_winner;
          w_grant_nxt = NREQ'(1) << w_winner;
`ifdef ARB_TIMEOUT_EN
          w_to_cnt_nxt = '0;
`endif
        end
      end
      S_RUN: begin
`ifdef ARB_TIMEOUT_EN
        w_to_cnt_nxt = r_to_cnt + CW'(1);
`endif
        // Completion outranks watchdog, which outranks the owner dropping req.
        if (io_arb.din[r_owner] && (r_det == 2'd2)) begin
          w_det_nxt     = 2'd3;
          w_state_nxt   = S_DONE;
          w_grant_nxt   = '0;
          w_done_nxt    = 1'b1;
          w_done_id_nxt = r_owner;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_to_cnt == CW'(TO_CYCLES - 1)) begin
          w_timeout_nxt = 1'b1;
          w_grant_nxt   = '0;
          w_det_nxt     = 2'd0;
          w_state_nxt   = S_IDLE;
          w_ptr_nxt     = w_ptr_inc;
        end
`endif
        else if (!io_arb.req[r_owner]) begin
          w_grant_nxt = '0;
          w_det_nxt   = 2'd0;
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_ptr_inc;
        end else if (io_arb.din[r_owner]) begin
          w_det_nxt = r_det + 2'd1;
        end
      end
      S_DONE: begin
        w_grant_nxt = '0;
        w_det_nxt   = 2'd0;
        w_ptr_nxt   = w_ptr_inc;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_det_nxt   = 2'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_done_id <= '0;
      r_grant   <= '0;
      r_det     <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_done_id <= w_done_id_nxt;
      r_grant   <= w_grant_nxt;
      r_det     <= w_det_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
`ifdef ARB_TIMEOUT_EN
      r_to_cnt  <= w_to_cnt_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  assign io_arb.grant     = r_grant;
  assign io_arb.busy      = r_busy;
  assign io_arb.det_state = r_det;
  assign io_arb.done      = r_done;
  assign io_arb.done_id   = r_done_id;
`ifdef ARB_TIMEOUT_EN
  assign io_arb.timeout   = r_timeout;
`else
  // No watchdog: TO_CYCLES is only folded in so the parameter stays referenced.
  assign io_arb.timeout   = (TO_CYCLES < 0);
`endif
endmodule

// File: tb/tb_moore_detector_arbiter.sv
// tb/tb_moore_detector_arbiter.sv - self-checking bench for moore_detector_arbiter
module tb_moore_detector_arbiter;
  localparam int NREQ      = 4;
  localparam int TO_CYCLES = 16;
  localparam int IDW       = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  moore_detector_arbiter_if #(.NREQ(NREQ)) arb_if ();

  moore_detector_arbiter #(.NREQ(NREQ), .TO_CYCLES(TO_CYCLES)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_arb (arb_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    arb_if.req = '0;
    arb_if.din = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Scoreboard: every done pulse must match the next expected owner id.
  always @(negedge clk) begin
    if (rst === 1'b1 && arb_if.done === 1'b1) begin : sb_pop
      int e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: done=1 done_id=%0d, required no done", arb_if.done_id);
      end else begin
        e = exp_q.pop_front();
        if (arb_if.done_id !== IDW'(e)) begin
          n_err++;
          $display("FAIL done_id: got %0d, required %0d", arb_if.done_id, e);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b0;
    arb_if.req = '0;
    arb_if.din = '0;
    tick();
    tick();
    n_cmp++;
    if ({arb_if.grant, arb_if.busy, arb_if.det_state, arb_if.done, arb_if.done_id, arb_if.timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_state: grant=%b busy=%b det=%0d done=%b id=%0d to=%b, required all 0",
               arb_if.grant, arb_if.busy, arb_if.det_state, arb_if.done, arb_if.done_id, arb_if.timeout);
    end
    rst = 1'b1;
  endtask

  task automatic test_single;
    arb_if.req = 4'b0001;
    arb_if.din = 4'b0000;
    tick();
    n_cmp++;
    if (arb_if.grant !== 4'b0001 || arb_if.busy !== 1'b1 || arb_if.det_state !== 2'd0) begin
      n_err++;
      $display("FAIL single_grant: grant=%b busy=%b det=%0d, required 0001 1 0",
               arb_if.grant, arb_if.busy, arb_if.det_state);
    end
    arb_if.din = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) exp_q.push_back(0);
      tick();
      n_cmp++;
      if (arb_if.det_state !== 2'(k)) begin
        n_err++;
        $display("FAIL single_det%0d: got %0d, required %0d", k, arb_if.det_state, k);
      end
    end
    n_cmp++;
    if (arb_if.done !== 1'b1 || arb_if.grant !== 4'b0000 || arb_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: done=%b grant=%b busy=%b, required 1 0000 1",
               arb_if.done, arb_if.grant, arb_if.busy);
    end
    arb_if.req = '0;
    arb_if.din = '0;
    tick();
    n_cmp++;
    if (arb_if.done !== 1'b0 || arb_if.det_state !== 2'd0 || arb_if.busy !== 1'b0 || arb_if.grant !== 4'b0000) begin
      n_err++;
      $display("FAIL single_after: done=%b det=%0d busy=%b grant=%b, required 0 0 0 0000",
               arb_if.done, arb_if.det_state, arb_if.busy, arb_if.grant);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] eg;
    int w;
    apply_reset();
    arb_if.req = 4'b1111;
    arb_if.din = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      w = 0;
      while (arb_if.grant === 4'b0000 && w < 8) begin
        tick();
        w++;
      end
      eg = 4'(1 << (n % NREQ));
      n_cmp++;
      if (arb_if.grant !== eg) begin
        n_err++;
        $display("FAIL rr_grant%0d: got %b, required %b", n, arb_if.grant, eg);
      end
      exp_q.push_back(n % NREQ);
      tick();
      tick();
      tick();
      n_cmp++;
      if (arb_if.done !== 1'b1 || arb_if.grant !== 4'b0000) begin
        n_err++;
        $display("FAIL rr_done%0d: done=%b grant=%b, required 1 0000", n, arb_if.done, arb_if.grant);
      end
    end
    arb_if.req = '0;
    arb_if.din = '0;
    tick();
    tick();
  endtask

  task automatic test_abort;
    apply_reset();
    arb_if.req = 4'b0100;
    arb_if.din = 4'b0000;
    tick();
    n_cmp++;
    if (arb_if.grant !== 4'b0100) begin
      n_err++;
      $display("FAIL abort_grant: got %b, required 0100", arb_if.grant);
    end
    arb_if.din = 4'b0100;
    tick();
    tick();
    n_cmp++;
    if (arb_if.det_state !== 2'd2) begin
      n_err++;
      $display("FAIL abort_det2: got %0d, required 2", arb_if.det_state);
    end
    arb_if.req = 4'b1001;
    arb_if.din = 4'b0000;
    tick();
    n_cmp++;
    if (arb_if.grant !== 4'b0000 || arb_if.det_state !== 2'd0 || arb_if.done !== 1'b0 || arb_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_drop: grant=%b det=%0d done=%b busy=%b, required 0000 0 0 0",
               arb_if.grant, arb_if.det_state, arb_if.done, arb_if.busy);
    end
    tick();
    n_cmp++;
    if (arb_if.grant !== 4'b1000) begin
      n_err++;
      $display("FAIL abort_next: got %b, required 1000", arb_if.grant);
    end
    arb_if.req = '0;
    tick();
    tick();
  endtask

  task automatic test_owner_select;
    logic [3:0] dins [4] = '{4'b1011, 4'b1001, 4'b0010, 4'b1011};
    logic [1:0] dets [4] = '{2'd1, 2'd1, 2'd2, 2'd3};
    apply_reset();
    arb_if.req = 4'b0010;
    arb_if.din = 4'b0000;
    tick();
    n_cmp++;
    if (arb_if.grant !== 4'b0010) begin
      n_err++;
      $display("FAIL sel_grant: got %b, required 0010", arb_if.grant);
    end
    for (int k = 0; k < 4; k++) begin
      arb_if.din = dins[k];
      if (k == 3) begin
        arb_if.req = 4'b0000;
        exp_q.push_back(1);
      end
      tick();
      n_cmp++;
      if (arb_if.det_state !== dets[k]) begin
        n_err++;
        $display("FAIL sel_det%0d: got %0d, required %0d", k, arb_if.det_state, dets[k]);
      end
    end
    n_cmp++;
    if (arb_if.done !== 1'b1 || arb_if.grant !== 4'b0000) begin
      n_err++;
      $display("FAIL sel_done: done=%b grant=%b, required 1 0000", arb_if.done, arb_if.grant);
    end
    arb_if.din = '0;
    tick();
  endtask

  task automatic test_reset_mid_run;
    arb_if.req = 4'b1111;
    arb_if.din = 4'b0000;
    tick();
    n_cmp++;
    if (arb_if.grant !== 4'b0100) begin
      n_err++;
      $display("FAIL midrst_grant: got %b, required 0100", arb_if.grant);
    end
    arb_if.din = 4'b0100;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (arb_if.grant !== 4'b0000 || arb_if.busy !== 1'b0 || arb_if.det_state !== 2'd0 || arb_if.done !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_hold%0d: grant=%b busy=%b det=%0d done=%b, required 0000 0 0 0",
                 k, arb_if.grant, arb_if.busy, arb_if.det_state, arb_if.done);
      end
    end
    rst = 1'b1;
    arb_if.din = '0;
    tick();
    n_cmp++;
    if (arb_if.grant !== 4'b0001) begin
      n_err++;
      $display("FAIL midrst_ptr: got %b, required 0001", arb_if.grant);
    end
    arb_if.req = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    int bad;
    apply_reset();
    arb_if.req = 4'b0001;
    arb_if.din = 4'b0000;
    tick();
    n_cmp++;
    if (arb_if.grant !== 4'b0001) begin
      n_err++;
      $display("FAIL to_grant: got %b, required 0001", arb_if.grant);
    end
    bad = 0;
`ifdef ARB_TIMEOUT_EN
    repeat (TO_CYCLES - 1) begin
      tick();
      if (arb_if.timeout !== 1'b0 || arb_if.grant !== 4'b0001) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL to_early: %0d early cycles, required 0", bad);
    end
    tick();
    n_cmp++;
    if (arb_if.timeout !== 1'b1 || arb_if.grant !== 4'b0000 || arb_if.done !== 1'b0 || arb_if.det_state !== 2'd0) begin
      n_err++;
      $display("FAIL to_pulse: to=%b grant=%b done=%b det=%0d, required 1 0000 0 0",
               arb_if.timeout, arb_if.grant, arb_if.done, arb_if.det_state);
    end
    tick();
    n_cmp++;
    if (arb_if.timeout !== 1'b0 || arb_if.grant !== 4'b0001) begin
      n_err++;
      $display("FAIL to_after: to=%b grant=%b, required 0 0001", arb_if.timeout, arb_if.grant);
    end
`else
    repeat (100) begin
      tick();
      if (arb_if.timeout !== 1'b0 || arb_if.grant !== 4'b0001) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL to_none: %0d cycles with timeout or lost grant, required 0", bad);
    end
`endif
    arb_if.req = '0;
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    arb_if.req = '0;
    arb_if.din = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_owner_select();
    test_reset_mid_run();
    test_timeout();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d done pulses missing, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
